// File: rtl/spi_rom_responder.sv
// SPI mode-0 READ target that streams bytes from a byte-wide synchronous memory port on MISO.
// Define FAST_READ_EN to also accept FAST READ (0x0B), which adds 8 dummy clocks after the address.
module spi_rom_responder #(
    parameter int         ADDR_BITS   = 24,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] READ_CMD    = 8'h03
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_cs_n,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 spi_miso_oe,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_rd,
    input  logic [7:0]           mem_data,
    output logic                 active,
    output logic                 bad_cmd
);
    localparam int SHIFT_W = (ADDR_BITS > 8) ? ADDR_BITS : 8;
    localparam int CNT_W   = $clog2(SHIFT_W + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE_BIT = CNT_W'(7);
    localparam logic [CNT_W-1:0] LAST_ADDR_BIT = CNT_W'(ADDR_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_IGNORE
`ifdef FAST_READ_EN
        , S_DUMMY
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [SHIFT_W-1:0]     shift_q, shift_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic                   mem_rd_q, mem_rd_d;
    logic                   capture_q, capture_d;
    logic [7:0]             tx_buf_q, tx_buf_d;
    logic                   buf_valid_q, buf_valid_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   active_q, active_d;
    logic                   bad_cmd_q, bad_cmd_d;
`ifdef FAST_READ_EN
    logic                   fast_q, fast_d;
`endif

    logic               cs_s, sclk_s, mosi_s, sclk_rise, sclk_fall;
    logic [SHIFT_W-1:0] shift_next;

    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise  = sclk_s & ~sclk_prev_q;
    assign sclk_fall  = ~sclk_s & sclk_prev_q;
    assign shift_next = {shift_q[SHIFT_W-2:0], mosi_s};

    always_comb begin
        state_d     = state_q;
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_prev_d = sclk_s;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        capture_d   = mem_rd_q;
        tx_buf_d    = tx_buf_q;
        buf_valid_d = buf_valid_q;
        tx_shift_d  = tx_shift_q;
        miso_d      = miso_q;
        bad_cmd_d   = 1'b0;
`ifdef FAST_READ_EN
        fast_d      = fast_q;
`endif
        // Memory data is valid one clk after the strobe; hold it until the next sclk fall.
        if (capture_q) begin
            tx_buf_d    = mem_data;
            buf_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (!cs_s) begin
                    state_d   = S_CMD;
                    bit_cnt_d = '0;
                end
            end
            S_CMD: begin
                if (sclk_rise) begin
                    shift_d   = shift_next;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BYTE_BIT) begin
                        bit_cnt_d = '0;
                        if (shift_next[7:0] == READ_CMD) begin
                            state_d = S_ADDR;
`ifdef FAST_READ_EN
                        end else if (shift_next[7:0] == 8'h0B) begin
                            state_d = S_ADDR;
                            fast_d  = 1'b1;
`endif
                        end else begin
                            state_d   = S_IGNORE;
                            bad_cmd_d = 1'b1;
                        end
                    end
                end
            end
            S_ADDR: begin
                if (sclk_rise) begin
                    shift_d   = shift_next;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_ADDR_BIT) begin
                        bit_cnt_d  = '0;
                        mem_addr_d = shift_next[ADDR_BITS-1:0];
`ifdef FAST_READ_EN
                        if (fast_q) begin
                            state_d = S_DUMMY;
                        end else begin
                            state_d  = S_DATA;
                            mem_rd_d = 1'b1;
                        end
`else
                        state_d  = S_DATA;
                        mem_rd_d = 1'b1;
`endif
                    end
                end
            end
`ifdef FAST_READ_EN
            S_DUMMY: begin
                if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BYTE_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                        mem_rd_d  = 1'b1;
                    end
                end
            end
`endif
            S_DATA: begin
                if (sclk_fall) begin
                    if (buf_valid_q) begin
                        miso_d      = tx_buf_q[7];
                        tx_shift_d  = {tx_buf_q[6:0], 1'b0};
                        buf_valid_d = 1'b0;
                    end else begin
                        miso_d     = tx_shift_q[7];
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
                if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BYTE_BIT) begin
                        bit_cnt_d  = '0;
                        mem_addr_d = mem_addr_q + ADDR_BITS'(1);
                        mem_rd_d   = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase

        // A deasserted chip select overrides any edge seen on the same clk.
        if (cs_s) begin
            state_d     = S_IDLE;
            bit_cnt_d   = '0;
            shift_d     = '0;
            mem_addr_d  = mem_addr_q;
            mem_rd_d    = 1'b0;
            capture_d   = 1'b0;
            buf_valid_d = 1'b0;
            tx_shift_d  = '0;
            bad_cmd_d   = 1'b0;
`ifdef FAST_READ_EN
            fast_d      = 1'b0;
`endif
        end
        if (state_d != S_DATA) miso_d = 1'b0;
        miso_oe_d = (state_d == S_DATA);
        active_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            capture_q   <= 1'b0;
            tx_buf_q    <= '0;
            buf_valid_q <= 1'b0;
            tx_shift_q  <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            active_q    <= 1'b0;
            bad_cmd_q   <= 1'b0;
`ifdef FAST_READ_EN
            fast_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            capture_q   <= capture_d;
            tx_buf_q    <= tx_buf_d;
            buf_valid_q <= buf_valid_d;
            tx_shift_q  <= tx_shift_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            active_q    <= active_d;
            bad_cmd_q   <= bad_cmd_d;
`ifdef FAST_READ_EN
            fast_q      <= fast_d;
`endif
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign active      = active_q;
    assign bad_cmd     = bad_cmd_q;
endmodule

// File: tb/tb_spi_rom_responder.sv
// Self-checking bench for spi_rom_responder: acts as SPI initiator and synchronous memory.
// Honours FAST_READ_EN the same way the design does.
module tb_spi_rom_responder;
    localparam int AB = 24;

    logic          clk = 1'b0;
    logic          reset, spi_cs_n, spi_sclk, spi_mosi;
    logic          spi_miso, spi_miso_oe, mem_rd, active, bad_cmd;
    logic [AB-1:0] mem_addr;
    logic [7:0]    mem_data = 8'h00;

    int checks = 0;
    int passed = 0;
    int half = 6;
    logic [7:0] key = 8'hA5;
    bit mix = 1'b0;

    logic [AB-1:0] rd_log[$];
    int bad_cnt = 0;
    int oe_cnt = 0;
    int miso_viol = 0;
    logic [7:0] rx_q[$];

    spi_rom_responder #(.ADDR_BITS(AB), .SYNC_STAGES(2), .READ_CMD(8'h03)) dut (
        .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
        .active(active), .bad_cmd(bad_cmd)
    );

    always #5 clk = ~clk;

    // Reference memory contents: low address byte xor a key, optionally mixed with upper bytes.
    function automatic logic [7:0] mem_byte(input logic [AB-1:0] a);
        mem_byte = a[7:0] ^ key ^ (mix ? (a[15:8] + a[23:16]) : 8'h00);
    endfunction

    always @(posedge clk) if (mem_rd) mem_data <= mem_byte(mem_addr);

    always @(negedge clk) begin
        if (mem_rd) rd_log.push_back(mem_addr);
        if (bad_cmd) bad_cnt++;
        if (spi_miso_oe) oe_cnt++;
        if (!spi_miso_oe && spi_miso) miso_viol++;
    end

    task automatic spi_bit(input logic tx, output logic rx, input bit end_cs);
        spi_mosi = tx;
        repeat (half) @(negedge clk);
        rx = spi_miso;
        spi_sclk = 1'b1;
        if (end_cs) spi_cs_n = 1'b1;
        repeat (half) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, input bit end_cs);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b, end_cs && (i == 0));
            rx[i] = b;
        end
    endtask

    task automatic cs_start();
        spi_sclk = 1'b0;
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_end();
        spi_cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // The final rise is issued together with cs_n high, so no prefetch follows the last byte.
    task automatic do_read(input logic [7:0] op, input logic [AB-1:0] addr, input int nbytes);
        logic [7:0] rx;
        rx_q.delete();
        cs_start();
        spi_byte(op, rx, 1'b0);
        spi_byte(addr[23:16], rx, 1'b0);
        spi_byte(addr[15:8], rx, 1'b0);
        spi_byte(addr[7:0], rx, 1'b0);
        for (int k = 0; k < nbytes; k++) begin
            spi_byte(8'($urandom), rx, k == nbytes - 1);
            rx_q.push_back(rx);
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_miso, spi_miso_oe, mem_rd, active, bad_cmd} !== 5'b0 || mem_addr !== '0)
            $display("[TB] FAIL reset_outputs: got miso=%b oe=%b rd=%b act=%b bad=%b addr=%h, want all 0",
                     spi_miso, spi_miso_oe, mem_rd, active, bad_cmd, mem_addr);
        else passed++;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (active !== 1'b0) $display("[TB] FAIL idle_after_reset: active=%b want 0", active);
        else passed++;
    endtask

    task automatic test_read_basic();
        logic [7:0] exp_b[4] = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
        int rd0 = rd_log.size();
        int oe0 = oe_cnt;
        do_read(8'h03, 24'h000010, 4);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rx_q[k] !== exp_b[k]) $display("[TB] FAIL basic_byte%0d: got %h want %h", k, rx_q[k], exp_b[k]);
            else passed++;
        end
        checks++;
        if (rd_log.size() - rd0 != 4) $display("[TB] FAIL basic_rd_count: got %0d want 4", rd_log.size() - rd0);
        else begin
            passed++;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rd_log[rd0 + k] !== AB'(24'h10 + k))
                    $display("[TB] FAIL basic_rd_addr%0d: got %h want %h", k, rd_log[rd0 + k], 24'h10 + k);
                else passed++;
            end
        end
        checks++;
        if (oe_cnt == oe0) $display("[TB] FAIL basic_oe: oe never high, want high during data");
        else passed++;
        checks++;
        if (active !== 1'b0 || spi_miso_oe !== 1'b0)
            $display("[TB] FAIL basic_end: active=%b oe=%b want 0 0", active, spi_miso_oe);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0]    exp_b[3] = '{8'h5B, 8'h5A, 8'hA5};
        logic [AB-1:0] exp_a[3] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000};
        int rd0 = rd_log.size();
        do_read(8'h03, 24'hFFFFFE, 3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rx_q[k] !== exp_b[k]) $display("[TB] FAIL wrap_byte%0d: got %h want %h", k, rx_q[k], exp_b[k]);
            else passed++;
        end
        checks++;
        if (rd_log.size() - rd0 != 3) $display("[TB] FAIL wrap_rd_count: got %0d want 3", rd_log.size() - rd0);
        else begin
            passed++;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rd_log[rd0 + k] !== exp_a[k])
                    $display("[TB] FAIL wrap_rd_addr%0d: got %h want %h", k, rd_log[rd0 + k], exp_a[k]);
                else passed++;
            end
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] ops[2];
        logic [7:0] rx;
        ops[0] = 8'h9F;
        do ops[1] = 8'($urandom_range(0, 255)); while (ops[1] == 8'h03 || ops[1] == 8'h0B);
        for (int t = 0; t < 2; t++) begin
            int rd0 = rd_log.size();
            int oe0 = oe_cnt;
            int bad0 = bad_cnt;
            logic [7:0] rx_or = 8'h00;
            cs_start();
            spi_byte(ops[t], rx, 1'b0);
            checks++;
            if (bad_cnt - bad0 != 1) $display("[TB] FAIL bad_pulse_%h: got %0d pulses want 1", ops[t], bad_cnt - bad0);
            else passed++;
            for (int k = 0; k < 4; k++) begin
                spi_byte(8'($urandom), rx, 1'b0);
                rx_or |= rx;
            end
            checks++;
            if (active !== 1'b1) $display("[TB] FAIL bad_active_%h: got %b want 1", ops[t], active);
            else passed++;
            checks++;
            if (bad_cnt - bad0 != 1 || rd_log.size() != rd0 || oe_cnt != oe0 || rx_or !== 8'h00)
                $display("[TB] FAIL bad_quiet_%h: bad=%0d rd=%0d oe=%0d miso_or=%h want 1 0 0 00",
                         ops[t], bad_cnt - bad0, rd_log.size() - rd0, oe_cnt - oe0, rx_or);
            else passed++;
            cs_end();
            checks++;
            if (active !== 1'b0) $display("[TB] FAIL bad_release_%h: active=%b want 0", ops[t], active);
            else passed++;
        end
    endtask

    task automatic test_cs_abort();
        logic [7:0] rx;
        logic b;
        int n = 0;
        cs_start();
        spi_byte(8'h03, rx, 1'b0);
        for (int i = 0; i < 13; i++) spi_bit(1'($urandom), b, 1'b0);
        spi_cs_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (active === 1'b0) begin n = i; break; end
        end
        checks++;
        if (n == 0) $display("[TB] FAIL abort_active_drop: active=%b after 3 clks, want 0", active);
        else passed++;
        repeat (4) @(negedge clk);
        do_read(8'h03, 24'h000020, 1);
        checks++;
        if (rx_q[0] !== 8'h85) $display("[TB] FAIL abort_second_read: got %h want 85", rx_q[0]);
        else passed++;
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] rx;
        logic b;
        cs_start();
        spi_byte(8'h03, rx, 1'b0);
        spi_byte(8'h00, rx, 1'b0);
        spi_byte(8'h00, rx, 1'b0);
        spi_byte(8'h40, rx, 1'b0);
        spi_byte(8'h00, rx, 1'b0);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, b, 1'b0);
        checks++;
        if (spi_miso_oe !== 1'b1) $display("[TB] FAIL midreset_pre_oe: got %b want 1", spi_miso_oe);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({spi_miso, spi_miso_oe, mem_rd, active, bad_cmd} !== 5'b0 || mem_addr !== '0)
            $display("[TB] FAIL midreset_outputs: got miso=%b oe=%b rd=%b act=%b bad=%b addr=%h, want all 0",
                     spi_miso, spi_miso_oe, mem_rd, active, bad_cmd, mem_addr);
        else passed++;
        spi_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        do_read(8'h03, 24'h000000, 1);
        checks++;
        if (rx_q[0] !== 8'hA5) $display("[TB] FAIL midreset_reread: got %h want A5", rx_q[0]);
        else passed++;
    endtask

`ifdef FAST_READ_EN
    task automatic test_fast_read();
        logic [7:0] rx;
        logic b;
        int rd0 = rd_log.size();
        int oe0;
        cs_start();
        spi_byte(8'h0B, rx, 1'b0);
        spi_byte(8'h00, rx, 1'b0);
        spi_byte(8'h00, rx, 1'b0);
        spi_byte(8'h10, rx, 1'b0);
        checks++;
        if (rd_log.size() != rd0) $display("[TB] FAIL fast_no_early_rd: got %0d reads want 0", rd_log.size() - rd0);
        else passed++;
        oe0 = oe_cnt;
        for (int i = 0; i < 7; i++) spi_bit(1'b0, b, 1'b0);
        checks++;
        if (oe_cnt != oe0) $display("[TB] FAIL fast_dummy_oe: oe high %0d clks want 0", oe_cnt - oe0);
        else passed++;
        spi_bit(1'b0, b, 1'b0);
        spi_byte(8'h00, rx, 1'b0);
        checks++;
        if (rx !== 8'hB5) $display("[TB] FAIL fast_byte0: got %h want B5", rx);
        else passed++;
        spi_byte(8'h00, rx, 1'b1);
        checks++;
        if (rx !== 8'hB4) $display("[TB] FAIL fast_byte1: got %h want B4", rx);
        else passed++;
        repeat (6) @(negedge clk);
    endtask
`else
    task automatic test_fast_read();
        logic [7:0] rx;
        logic [7:0] rx_or = 8'h00;
        int rd0 = rd_log.size();
        int oe0 = oe_cnt;
        int bad0 = bad_cnt;
        cs_start();
        for (int k = 0; k < 5; k++) begin
            spi_byte((k == 0) ? 8'h0B : 8'h00, rx, 1'b0);
            rx_or |= rx;
        end
        checks++;
        if (bad_cnt - bad0 != 1) $display("[TB] FAIL fast_disabled_bad: got %0d pulses want 1", bad_cnt - bad0);
        else passed++;
        checks++;
        if (oe_cnt != oe0 || rd_log.size() != rd0 || rx_or !== 8'h00)
            $display("[TB] FAIL fast_disabled_quiet: oe=%0d rd=%0d miso_or=%h want 0 0 00",
                     oe_cnt - oe0, rd_log.size() - rd0, rx_or);
        else passed++;
        cs_end();
    endtask
`endif

    task automatic test_random_reads();
        mix = 1'b1;
        for (int t = 0; t < 6; t++) begin
            logic [AB-1:0] addr;
            int nb = $urandom_range(1, 5);
            int rd0 = rd_log.size();
            half = $urandom_range(4, 8);
            key = 8'($urandom);
            addr = ($urandom_range(0, 1) == 1) ? AB'(24'hFFFFFF - $urandom_range(0, 3)) : AB'($urandom);
            do_read(8'h03, addr, nb);
            for (int k = 0; k < nb; k++) begin
                logic [AB-1:0] a = addr + AB'(k);
                checks++;
                if (rx_q[k] !== mem_byte(a))
                    $display("[TB] FAIL rand%0d_byte%0d @%h: got %h want %h", t, k, a, rx_q[k], mem_byte(a));
                else passed++;
            end
            checks++;
            if (rd_log.size() - rd0 != nb)
                $display("[TB] FAIL rand%0d_rd_count: got %0d want %0d", t, rd_log.size() - rd0, nb);
            else begin
                passed++;
                checks++;
                if (rd_log[$] !== AB'(addr + AB'(nb - 1)))
                    $display("[TB] FAIL rand%0d_last_addr: got %h want %h", t, rd_log[$], addr + AB'(nb - 1));
                else passed++;
            end
        end
        mix = 1'b0;
        key = 8'hA5;
        half = 6;
    endtask

    task automatic test_miso_quiet();
        checks++;
        if (miso_viol != 0) $display("[TB] FAIL miso_quiet: miso high with oe low on %0d clks, want 0", miso_viol);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_wrap();
        test_bad_cmd();
        test_cs_abort();
        test_reset_mid_data();
        test_fast_read();
        test_random_reads();
        test_miso_quiet();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
